// File: rtl/display_scheduler.sv
// display_scheduler: view FSM, alarm-ring override, edit blink and ALARM-view
// timeout for the shared 8-digit seven-segment scan driver. All outputs are
// registered one clk behind the state/inputs they reflect.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit
// (digit 7) in the TIME view.
module display_scheduler #(
  parameter int         BLINK_HALF  = 25_000_000,
  parameter int         TIMEOUT_CYC = 1_000_000_000,
  parameter logic [7:0] EN_TIME     = 8'hFF,
  parameter logic [7:0] EN_ALARM    = 8'hF0,
  parameter logic [7:0] EN_SW       = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] time_dig,
  input  logic [7:0]  time_pt,
  input  logic [31:0] alm_dig,
  input  logic [7:0]  alm_pt,
  input  logic [31:0] sw_dig,
  input  logic [7:0]  sw_pt,
  input  logic        mode_next,
  input  logic        activity,
  input  logic [7:0]  edit_mask,
  input  logic        alarm_ring,
  output logic [3:0]  d7,
  output logic [3:0]  d6,
  output logic [3:0]  d5,
  output logic [3:0]  d4,
  output logic [3:0]  d3,
  output logic [3:0]  d2,
  output logic [3:0]  d1,
  output logic [3:0]  d0,
  output logic [7:0]  en,
  output logic [7:0]  en_point,
  output logic [1:0]  mode,
  output logic        ring_ack
);
  localparam int BW = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_TIME = 2'd0, S_ALARM = 2'd1, S_SW = 2'd2, S_RING = 2'd3} state_t;

  state_t          state, state_d, saved;
  logic            phase;
  logic [BW-1:0]   blink_cnt;
  logic [TW-1:0]   to_cnt;
  logic [7:0]      edit_q;
  logic            to_hit;
  logic [7:0][3:0] sel_dig, dig_q;
  logic [7:0]      sel_pt, en_d;

  assign to_hit = (state == S_ALARM) && !activity && (to_cnt == TO_LAST);

  // Next view: ring override first, then mode_next, then ALARM idle timeout.
  always_comb begin
    state_d = state;
    case (state)
      S_TIME:  if (alarm_ring) state_d = S_RING;
               else if (mode_next) state_d = S_ALARM;
      S_ALARM: if (alarm_ring) state_d = S_RING;
               else if (mode_next) state_d = S_SW;
               else if (to_hit) state_d = S_TIME;
      S_SW:    if (alarm_ring) state_d = S_RING;
               else if (mode_next) state_d = S_TIME;
      default: if (!alarm_ring) state_d = (saved == S_ALARM) ? S_TIME : saved;
    endcase
  end

  // Source select and blink-masked enables for the current view.
  always_comb begin
    sel_dig = time_dig;
    sel_pt  = time_pt;
    en_d    = EN_TIME & ~(edit_mask & {8{~phase}});
    case (state)
      S_ALARM: begin
        sel_dig = alm_dig;
        sel_pt  = alm_pt;
        en_d    = EN_ALARM & ~(edit_mask & {8{~phase}});
      end
      S_SW: begin
        sel_dig = sw_dig;
        sel_pt  = sw_pt;
        en_d    = EN_SW & ~(edit_mask & {8{~phase}});
      end
      S_RING: begin
        sel_dig = alm_dig;
        sel_pt  = alm_pt;
        en_d    = phase ? EN_ALARM : 8'h00;
      end
      default: ;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (state == S_TIME && time_dig[31:28] == 4'h0) en_d[7] = 1'b0;
`endif
  end

  // State, saved view, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_TIME;
      saved     <= S_TIME;
      phase     <= 1'b1;
      blink_cnt <= '0;
      to_cnt    <= '0;
      edit_q    <= 8'h00;
      dig_q     <= '0;
      en        <= 8'h00;
      en_point  <= 8'h00;
      mode      <= 2'd0;
      ring_ack  <= 1'b0;
    end else begin
      state  <= state_d;
      edit_q <= edit_mask;
      if (state != S_RING && state_d == S_RING) saved <= state;
      // Idle count runs only while staying in ALARM without keypresses.
      if (state == S_ALARM && state_d == S_ALARM && !activity) to_cnt <= to_cnt + TW'(1);
      else to_cnt <= '0;
      // Blink restarts visible so a freshly selected digit shows at once.
      if (state_d != state || edit_mask != edit_q) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
      dig_q    <= sel_dig;
      en       <= en_d;
      en_point <= sel_pt & en_d;
      mode     <= state;
      ring_ack <= (state == S_RING) && mode_next;
    end
  end

  assign d0 = dig_q[0];
  assign d1 = dig_q[1];
  assign d2 = dig_q[2];
  assign d3 = dig_q[3];
  assign d4 = dig_q[4];
  assign d5 = dig_q[5];
  assign d6 = dig_q[6];
  assign d7 = dig_q[7];
endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: vector table, hand sequences for timeout,
// blink, ring and async reset, then randomized traffic against a model.
module tb_display_scheduler;
  localparam int BH = 4;
  localparam int TO = 20;
  localparam logic [31:0] TD = 32'h1234_5678, AD = 32'h9ABC_DEF0, SD = 32'h0011_2233;
  localparam logic [7:0]  TP = 8'h04, AP = 8'h40, SP = 8'hAA;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] time_dig, alm_dig, sw_dig;
  logic [7:0]  time_pt, alm_pt, sw_pt, edit_mask, en, en_point;
  logic        mode_next, activity, alarm_ring, ring_ack;
  logic [3:0]  d7, d6, d5, d4, d3, d2, d1, d0;
  logic [1:0]  mode;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  display_scheduler #(.BLINK_HALF(BH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .time_dig(time_dig), .time_pt(time_pt),
    .alm_dig(alm_dig), .alm_pt(alm_pt), .sw_dig(sw_dig), .sw_pt(sw_pt),
    .mode_next(mode_next), .activity(activity), .edit_mask(edit_mask),
    .alarm_ring(alarm_ring), .d7(d7), .d6(d6), .d5(d5), .d4(d4), .d3(d3),
    .d2(d2), .d1(d1), .d0(d0), .en(en), .en_point(en_point), .mode(mode),
    .ring_ack(ring_ack));

  wire [31:0] dig_w = {d7, d6, d5, d4, d3, d2, d1, d0};
  wire [50:0] out_w = {mode, ring_ack, en, en_point, dig_w};

  typedef struct {
    bit         mn;
    bit         ar;
    logic [1:0] mode;
    logic [7:0] en;
    bit         ack;
  } vec_t;
  vec_t tbl[21];

  // Reference model: view number, saved view, blink phase, blink/idle counts.
  int          m_st, m_sv, m_ph, m_bc, m_tc;
  logic [7:0]  m_em_prev;
  logic [1:0]  e_mode;
  logic        e_ack;
  logic [7:0]  e_en, e_pt;
  logic [31:0] e_dig;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] src(input logic [1:0] m);
    if (m == 2'd0) return {TP, TD};
    if (m == 2'd2) return {SP, SD};
    return {AP, AD};
  endfunction

  task automatic model_reset();
    m_st = 0; m_sv = 0; m_ph = 1; m_bc = 0; m_tc = 0; m_em_prev = 8'h00;
    e_mode = 2'd0; e_ack = 1'b0; e_en = 8'h00; e_pt = 8'h00; e_dig = 32'h0;
  endtask

  // Outputs expected after the next edge, then advance one cycle.
  task automatic model_step();
    logic [7:0] msk, pt;
    logic [31:0] dg;
    int nx;
    case (m_st)
      0:       begin dg = time_dig; pt = time_pt; msk = 8'hFF; end
      2:       begin dg = sw_dig;   pt = sw_pt;   msk = 8'hFF; end
      default: begin dg = alm_dig;  pt = alm_pt;  msk = 8'hF0; end
    endcase
    if (m_st == 3) e_en = (m_ph != 0) ? 8'hF0 : 8'h00;
    else           e_en = (m_ph != 0) ? msk : (msk & ~edit_mask);
`ifdef LEADING_ZERO_BLANK_EN
    if (m_st == 0 && time_dig[31:28] == 4'h0) e_en[7] = 1'b0;
`endif
    e_pt = pt & e_en;
    e_dig = dg;
    e_mode = 2'(m_st);
    e_ack = (m_st == 3) && mode_next;
    nx = m_st;
    if (m_st != 3 && alarm_ring) begin m_sv = m_st; nx = 3; end
    else if (m_st == 3) begin if (!alarm_ring) nx = (m_sv == 1) ? 0 : m_sv; end
    else if (mode_next) nx = (m_st + 1) % 3;
    else if (m_st == 1 && !activity && m_tc == TO - 1) nx = 0;
    m_tc = (m_st == 1 && nx == 1 && !activity) ? m_tc + 1 : 0;
    if (nx != m_st || edit_mask != m_em_prev) begin m_bc = 0; m_ph = 1; end
    else begin
      m_bc++;
      if (m_bc == BH) begin m_bc = 0; m_ph = 1 - m_ph; end
    end
    m_em_prev = edit_mask;
    m_st = nx;
  endtask

  task automatic do_reset();
    mode_next = 1'b0; activity = 1'b0; alarm_ring = 1'b0; edit_mask = 8'h00;
    rst_n = 1'b0;
    #7;
    chk("reset_outputs", 64'(out_w), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Cycles the mode output shows ALARM after a single entry pulse.
  task automatic timeout_run(input int act_at, input int exp_cnt, input string nm);
    int cnt;
    bit done;
    cnt = 0; done = 0;
    do_reset();
    mode_next = 1'b1; tick(); mode_next = 1'b0;
    for (int k = 1; k <= 100 && !done; k++) begin
      activity = (k == act_at);
      tick();
      if (mode == 2'd1) cnt++;
      else if (cnt > 0) done = 1;
    end
    activity = 1'b0;
    chk(nm, 64'(cnt), 64'(exp_cnt));
    chk({nm, "_back_to_time"}, 64'(mode), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 2'd0, 8'hFF, 0};
    tbl[1]  = '{1, 0, 2'd0, 8'hFF, 0};
    tbl[2]  = '{0, 0, 2'd1, 8'hF0, 0};
    tbl[3]  = '{1, 0, 2'd1, 8'hF0, 0};
    tbl[4]  = '{0, 0, 2'd2, 8'hFF, 0};
    tbl[5]  = '{0, 1, 2'd2, 8'hFF, 0};
    tbl[6]  = '{0, 1, 2'd3, 8'hF0, 0};
    tbl[7]  = '{1, 1, 2'd3, 8'hF0, 1};
    tbl[8]  = '{0, 1, 2'd3, 8'hF0, 0};
    tbl[9]  = '{0, 1, 2'd3, 8'hF0, 0};
    tbl[10] = '{0, 1, 2'd3, 8'h00, 0};
    tbl[11] = '{0, 0, 2'd3, 8'h00, 0};
    tbl[12] = '{0, 0, 2'd2, 8'hFF, 0};
    tbl[13] = '{1, 1, 2'd2, 8'hFF, 0};
    tbl[14] = '{0, 1, 2'd3, 8'hF0, 0};
    tbl[15] = '{0, 0, 2'd3, 8'hF0, 0};
    tbl[16] = '{1, 0, 2'd2, 8'hFF, 0};
    tbl[17] = '{1, 0, 2'd0, 8'hFF, 0};
    tbl[18] = '{0, 1, 2'd1, 8'hF0, 0};
    tbl[19] = '{0, 0, 2'd3, 8'hF0, 0};
    tbl[20] = '{0, 0, 2'd0, 8'hFF, 0};

    time_dig = TD; alm_dig = AD; sw_dig = SD;
    time_pt = TP; alm_pt = AP; sw_pt = SP;

    // Vector table: mode walk, ring from SW, ring+mode_next, ring from ALARM.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      logic [39:0] s;
      mode_next = tbl[i].mn; alarm_ring = tbl[i].ar;
      tick();
      s = src(tbl[i].mode);
      chk($sformatf("vec%0d", i), 64'(out_w),
          64'({tbl[i].mode, tbl[i].ack, tbl[i].en, s[39:32] & tbl[i].en, s[31:0]}));
    end
    mode_next = 1'b0; alarm_ring = 1'b0;

    // ALARM idle timeout, with and without a keypress at clk 15.
    timeout_run(0, TO, "timeout_idle");
    timeout_run(15, 35, "timeout_activity");

    // mode_next coinciding with the timeout goes to SW.
    do_reset();
    mode_next = 1'b1; tick(); mode_next = 1'b0;
    repeat (TO - 1) tick();
    mode_next = 1'b1; tick(); mode_next = 1'b0;
    chk("to_vs_mn_pre", 64'(mode), 64'd1);
    tick();
    chk("to_vs_mn", 64'(mode), 64'd2);

    // Edit blink in TIME; a mask change restarts visible.
    do_reset();
    edit_mask = 8'h30;
    for (int j = 0; j <= 12; j++) begin
      tick();
      chk($sformatf("blink%0d", j), 64'(en),
          64'((j == 0 || (((j - 1) / 4) % 2) == 0) ? 8'hFF : 8'hCF));
    end
    edit_mask = 8'h0C;
    tick();
    chk("blink_change_old_phase", 64'(en), 64'hF3);
    tick();
    chk("blink_change_visible", 64'(en), 64'hFF);
    edit_mask = 8'h00;

    // Simultaneous ring + mode_next from TIME, ring_ack, async reset in RING.
    do_reset();
    alarm_ring = 1'b1; mode_next = 1'b1; tick(); mode_next = 1'b0;
    chk("ring_same_cycle_mode", 64'({mode, ring_ack}), 64'({2'd0, 1'b0}));
    tick();
    chk("ring_entry", 64'({mode, ring_ack, en}), 64'({2'd3, 1'b0, 8'hF0}));
    mode_next = 1'b1; tick(); mode_next = 1'b0;
    chk("ring_ack", 64'({mode, ring_ack}), 64'({2'd3, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_in_ring", 64'({mode, ring_ack, en}), 64'h0);
    alarm_ring = 1'b0;

    // Hour-tens zero blanking.
    do_reset();
    time_dig = 32'h0930_4500; time_pt = 8'hFF;
    tick(); tick();
`ifdef LEADING_ZERO_BLANK_EN
    chk("lead_zero_en", 64'({en, en_point}), 64'({8'h7F, 8'h7F}));
`else
    chk("lead_zero_en", 64'({en, en_point}), 64'({8'hFF, 8'hFF}));
`endif
    time_dig = 32'h1230_4500;
    tick();
    chk("lead_nonzero_en", 64'({en, en_point}), 64'({8'hFF, 8'hFF}));
    time_dig = TD; time_pt = TP;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int rate;
      chk($sformatf("rand%0d", c), 64'(out_w), 64'({e_mode, e_ack, e_en, e_pt, e_dig}));
      rate = (((c / 200) % 2) == 1) ? 60 : 4;
      mode_next = ($urandom_range(rate - 1) == 0);
      activity  = ($urandom_range(29) == 0);
      if ($urandom_range(39) == 0) alarm_ring = ~alarm_ring;
      if ($urandom_range(24) == 0) edit_mask = 8'($urandom);
      time_dig = $urandom; alm_dig = $urandom; sw_dig = $urandom;
      time_pt = 8'($urandom); alm_pt = 8'($urandom); sw_pt = 8'($urandom);
      model_step();
      tick();
    end
    chk("rand_final", 64'(out_w), 64'({e_mode, e_ack, e_en, e_pt, e_dig}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Controller for the shared 8-digit seven-segment scan driver.
- Chooses which of three digit sources (time, alarm setting, stopwatch) owns the display, using a mode state machine.
- Forces an alarm-ring view, blinks the digits being edited, and times out of the alarm view back to the time view.
- Drives the scan driver's d7..d0, en and en_point inputs from registered outputs.

Parameters:
- BLINK_HALF, 25_000_000: clk cycles per blink half-period (0.25 s at 100 MHz).
- TIMEOUT_CYC, 1_000_000_000: idle clk cycles in ALARM view before returning to TIME (10 s at 100 MHz).
- EN_TIME, 8'hFF: digit enable mask in TIME view.
- EN_ALARM, 8'hF0: digit enable mask in ALARM and RING views.
- EN_SW, 8'hFF: digit enable mask in SW view.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- time_dig, in, 32: TIME source; nibble k is digit k.
- time_pt, in, 8: TIME source decimal points.
- alm_dig, in, 32: ALARM source digits.
- alm_pt, in, 8: ALARM source decimal points.
- sw_dig, in, 32: stopwatch source digits.
- sw_pt, in, 8: stopwatch source decimal points.
- mode_next, in, 1: one-cycle pulse from a debounced button.
- activity, in, 1: one-cycle pulse on any edit keypress.
- edit_mask, in, 8: digits currently being edited; these blink.
- alarm_ring, in, 1: level input; high while the alarm sounds.
- d7 .. d0, out, 4 each: digit values to the scan driver.
- en, out, 8: digit enables.
- en_point, out, 8: decimal point enables.
- mode, out, 2: current view; 0 TIME, 1 ALARM, 2 SW, 3 RING.
- ring_ack, out, 1: one-cycle pulse; mode_next pressed during RING.

Behaviour:
- Reset values: state TIME, saved state TIME, blink phase visible (1), both counters 0. All outputs 0 except en = 8'h00 until the first clock after reset release.
- All outputs are registered. Latency from an input or state change to the outputs is 1 clk.
- FSM states: TIME, ALARM, SW, RING.
- mode_next in TIME goes to ALARM; in ALARM goes to SW; in SW goes to TIME.
- alarm_ring high in TIME, ALARM or SW:
  - saves the current state and enters RING on the next edge;
  - has priority over a simultaneous mode_next, which is dropped.
- RING exit: when alarm_ring falls, return to the saved state. If the saved state was ALARM, return to TIME instead, and clear the timeout counter.
- mode_next in RING does not change state. It produces ring_ack high for exactly one cycle, registered.
- ALARM timeout:
  - Counter increments each clk while in ALARM.
  - Cleared on activity, on ALARM entry, and in any other state.
  - At count == TIMEOUT_CYC-1, go to TIME.
  - If mode_next coincides with the timeout, go to SW (mode_next wins).
- Blink counter:
  - Counts 0..BLINK_HALF-1, wraps, and toggles the phase on wrap.
  - Restarts at 0 with phase visible on every state change and on any edit_mask change, so an edited digit shows immediately.
- Source select:
  - TIME → time_dig/time_pt; ALARM and RING → alm_dig/alm_pt; SW → sw_dig/sw_pt.
  - The mode mask is EN_TIME, EN_ALARM or EN_SW.
- en computation:
  - TIME, ALARM, SW: en = mask & ~(edit_mask & {8{~phase}}).
  - RING: en = phase ? EN_ALARM : 8'h00, so all enabled digits blink and edit_mask is ignored.
  - en_point = selected points & en, so blanked digits show no point.
- Digit values pass through unmodified, including when blanked.
- Counter widths: $clog2 of the parameter; no overflow past the terminal count.
- Asynchronous reset mid-operation returns to TIME immediately and drops any pending ring_ack.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in TIME view only, if nibble 7 of time_dig == 0, en[7] and en_point[7] are forced to 0. This is applied after blink masking.
- Not defined: digit 7 follows the normal enable rules; a hour-tens zero displays as "0".

Test Plan:
- Reset then 3 mode_next pulses, 10 clk apart → mode 0→1→2→0; d7..d0 follow the selected source 1 clk after each change; en = 8'hFF, then 8'hF0, then 8'hFF.
- ALARM view, no activity, BLINK_HALF=4, TIMEOUT_CYC=20 → mode returns to 0 exactly 20 clk after entry. Repeat with an activity pulse at clk 15 → return at clk 35.
- edit_mask=8'h30 in TIME, BLINK_HALF=4 → en alternates 8'hFF / 8'hCF every 4 clk. Changing edit_mask restarts the blink with the digits visible.
- In SW, raise alarm_ring → mode=3, en toggles 8'hF0/8'h00. A mode_next pulse gives one ring_ack cycle with mode still 3. Dropping alarm_ring → mode=2.
- alarm_ring and mode_next asserted in the same cycle from TIME → mode=3, no ring_ack. Assert rst_n=0 mid-RING → mode=0 and en=0 asynchronously.
- With LEADING_ZERO_BLANK_EN, time_dig=32'h0930_4500 → en=8'h7F. With time_dig=32'h1230_4500 → en=8'hFF.
